// File: rtl/cuif_types_pkg.sv
// Shared control-unit interface types: jump control select and fetch-unit states.
package cuif_types_pkg;

    typedef enum logic [1:0] {
        ctrlDefault = 2'b00,
        ctrlJ       = 2'b01,
        ctrlJR      = 2'b10
    } jctrl_t;

    typedef enum logic [1:0] {
        FETCH  = 2'b00,
        EXEC   = 2'b01,
        HALTED = 2'b10
    } fstate_t;

endpackage

// File: rtl/next_pc_calc.sv
// Purely combinational next-PC selection: JR > J > taken branch > pc+4.
// Code 2'b11 on jctrl_in falls through to the sequential/branch path.
module next_pc_calc
    import cuif_types_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic [WORD_W-1:0] pc,
    input  logic [1:0]        jctrl_in,
    input  logic              branch_taken,
    input  logic [15:0]       imm16,
    input  logic [25:0]       jaddr26,
    input  logic [WORD_W-1:0] jr_target,
    output logic [WORD_W-1:0] npc,
    output logic [WORD_W-1:0] next_pc
);

    logic [WORD_W-1:0] w_br_off;

    assign npc      = pc + 32'd4;
    assign w_br_off = {{14{imm16[15]}}, imm16, 2'b00};

    always_comb begin
        next_pc = npc;
        if (jctrl_in == ctrlJR) begin
            next_pc = jr_target;
        end else if (jctrl_in == ctrlJ) begin
            next_pc = {npc[31:28], jaddr26, 2'b00};
        end else if (branch_taken) begin
            next_pc = npc + w_br_off;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC owner and fetch handshake: FETCH -> EXEC -> FETCH, sticky HALTED until reset.
// Optional retire counter output under FETCH_RETIRE_CNT_EN.
module pc_fetch_unit
    import cuif_types_pkg::*;
#(
    parameter int                WORD_W  = 32,
    parameter logic [WORD_W-1:0] PC_INIT = 32'h0000_0000
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  logic [WORD_W-1:0] instr_in,
    input  logic              dmem_access,
    input  logic              dhit,
    input  logic [1:0]        jctrl_in,
    input  logic              branch_taken,
    input  logic [15:0]       imm16,
    input  logic [25:0]       jaddr26,
    input  logic [WORD_W-1:0] jr_target,
    input  logic              halt,
    output logic              iREN,
    output logic [WORD_W-1:0] iaddr,
    output logic [WORD_W-1:0] instr_out,
    output logic              instr_valid,
    output logic [WORD_W-1:0] npc,
    output logic              pc_en,
`ifdef FETCH_RETIRE_CNT_EN
    output logic [WORD_W-1:0] retire_cnt,
`endif
    output logic              halted
);

    fstate_t           r_state;
    logic [WORD_W-1:0] r_pc;
    logic [WORD_W-1:0] r_instr;
    logic [WORD_W-1:0] w_next_pc;
    logic              w_stall;
    logic              w_halt_now;

    next_pc_calc #(.WORD_W(WORD_W)) u_next_pc (
        .pc           (r_pc),
        .jctrl_in     (jctrl_in),
        .branch_taken (branch_taken),
        .imm16        (imm16),
        .jaddr26      (jaddr26),
        .jr_target    (jr_target),
        .npc          (npc),
        .next_pc      (w_next_pc)
    );

    // Instruction stays presented until its data-memory access completes.
    assign w_stall    = dmem_access & ~dhit;
    assign w_halt_now = (r_state == EXEC) & halt;

    assign iREN        = (r_state == FETCH);
    assign iaddr       = r_pc;
    assign instr_out   = r_instr;
    assign instr_valid = (r_state == EXEC);
    assign halted      = (r_state == HALTED);
    assign pc_en       = (r_state == EXEC) & ~halt & ~w_stall;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state <= FETCH;
            r_pc    <= PC_INIT;
            r_instr <= '0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (ihit) begin
                        r_instr <= instr_in;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    if (halt) begin
                        r_state <= HALTED;
                    end else if (!w_stall) begin
                        r_pc    <= w_next_pc;
                        r_state <= FETCH;
                    end
                end
                HALTED: r_state <= HALTED;
                default: r_state <= FETCH;
            endcase
        end
    end

`ifdef FETCH_RETIRE_CNT_EN
    logic [WORD_W-1:0] r_retire_cnt;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_retire_cnt <= '0;
        end else if (pc_en || w_halt_now) begin
            r_retire_cnt <= r_retire_cnt + 32'd1;
        end
    end

    assign retire_cnt = r_retire_cnt;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed plan scenarios plus randomized traffic against a behavioural model.
module tb_pc_fetch_unit;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit;
    logic [31:0] instr_in;
    logic        dmem_access;
    logic        dhit;
    logic [1:0]  jctrl_in;
    logic        branch_taken;
    logic [15:0] imm16;
    logic [25:0] jaddr26;
    logic [31:0] jr_target;
    logic        halt;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic [31:0] npc;
    logic        pc_en;
    logic        halted;
`ifdef FETCH_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    int total = 0;
    int bad   = 0;

    // Model: mode 0 = waiting for instruction, 1 = executing, 2 = stopped.
    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_cnt;

    pc_fetch_unit #(.WORD_W(32), .PC_INIT(32'h0000_0000)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .ihit         (ihit),
        .instr_in     (instr_in),
        .dmem_access  (dmem_access),
        .dhit         (dhit),
        .jctrl_in     (jctrl_in),
        .branch_taken (branch_taken),
        .imm16        (imm16),
        .jaddr26      (jaddr26),
        .jr_target    (jr_target),
        .halt         (halt),
        .iREN         (iREN),
        .iaddr        (iaddr),
        .instr_out    (instr_out),
        .instr_valid  (instr_valid),
        .npc          (npc),
        .pc_en        (pc_en),
`ifdef FETCH_RETIRE_CNT_EN
        .retire_cnt   (retire_cnt),
`endif
        .halted       (halted)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_target(input logic [31:0] pc);
        logic [31:0] seq;
        int          off;
        seq = pc + 32'd4;
        off = int'($signed(imm16)) * 4;
        if (jctrl_in == 2'd2) return jr_target;
        if (jctrl_in == 2'd1) return {seq[31:28], jaddr26, 2'b00};
        if (branch_taken)     return seq + 32'(off);
        return seq;
    endfunction

    function automatic bit model_commit();
        return (m_mode == 1) && !halt && !(dmem_access && !dhit);
    endfunction

    task automatic clr();
        nRST = 1'b1; ihit = 1'b0; instr_in = '0; dmem_access = 1'b0; dhit = 1'b0;
        jctrl_in = 2'd0; branch_taken = 1'b0; imm16 = '0; jaddr26 = '0;
        jr_target = '0; halt = 1'b0;
    endtask

    // Settle the current inputs and compare every output to the model.
    task automatic eval();
        #1;
        chk("iREN",        {31'd0, iREN},        {31'd0, (m_mode == 0)});
        chk("iaddr",       iaddr,                m_pc);
        chk("instr_out",   instr_out,            m_instr);
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, (m_mode == 1)});
        chk("npc",         npc,                  m_pc + 32'd4);
        chk("halted",      {31'd0, halted},      {31'd0, (m_mode == 2)});
        chk("pc_en",       {31'd0, pc_en},       {31'd0, model_commit()});
`ifdef FETCH_RETIRE_CNT_EN
        chk("retire_cnt",  retire_cnt,           m_cnt);
`endif
    endtask

    task automatic adv();
        bit commit;
        commit = model_commit();
        @(posedge CLK);
        if (!nRST) begin
            m_mode = 0; m_pc = 32'h0; m_instr = 32'h0; m_cnt = 32'h0;
        end else if (m_mode == 0) begin
            if (ihit) begin m_instr = instr_in; m_mode = 1; end
        end else if (m_mode == 1) begin
            if (halt) begin
                m_mode = 2; m_cnt = m_cnt + 32'd1;
            end else if (commit) begin
                m_pc = model_target(m_pc); m_mode = 0; m_cnt = m_cnt + 32'd1;
            end
        end
        @(negedge CLK);
    endtask

    task automatic do_reset();
        clr(); nRST = 1'b0; eval(); adv(); clr();
    endtask

    task automatic run_instr(input logic [1:0] jc, input logic bt, input logic [15:0] imm,
                             input logic [25:0] ja, input logic [31:0] jr);
        clr(); ihit = 1'b1; instr_in = $urandom; eval(); adv();
        clr(); jctrl_in = jc; branch_taken = bt; imm16 = imm; jaddr26 = ja; jr_target = jr;
        eval(); adv(); clr();
    endtask

    logic [31:0] saved;

    initial begin
        m_mode = 0; m_pc = 32'h0; m_instr = 32'h0; m_cnt = 32'h0;
        clr();
        nRST = 1'b0;
        @(negedge CLK);
        adv();

        // Reset state
        clr(); eval();
        chk("rst_iREN", {31'd0, iREN}, 32'd1);
        chk("rst_iaddr", iaddr, 32'h0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_pc_en", {31'd0, pc_en}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_npc", npc, 32'h4);

        // First instruction, sequential commit
        ihit = 1'b1; instr_in = 32'h2408_0005; eval(); adv();
        clr(); eval();
        chk("first_instr", instr_out, 32'h2408_0005);
        chk("first_pc_en", {31'd0, pc_en}, 32'd1);
        adv(); eval();
        chk("first_pc", iaddr, 32'h4);
        chk("first_iREN", {31'd0, iREN}, 32'd1);

        // Jumps
        run_instr(2'd2, 1'b0, 16'h0, 26'h0, 32'h0000_0010);
        chk("jr_setup", iaddr, 32'h0000_0010);
        run_instr(2'd1, 1'b0, 16'h0, 26'h000_0040, 32'h0);
        chk("j_target", iaddr, 32'h0000_0100);
        run_instr(2'd2, 1'b0, 16'h0, 26'h0, 32'h0000_0200);
        chk("jr_target", iaddr, 32'h0000_0200);

        // Branches, negative and positive offset
        run_instr(2'd2, 1'b0, 16'h0, 26'h0, 32'h0000_0020);
        run_instr(2'd0, 1'b1, 16'hFFFE, 26'h0, 32'h0);
        chk("br_neg", iaddr, 32'h0000_001C);
        run_instr(2'd2, 1'b0, 16'h0, 26'h0, 32'h0000_0020);
        run_instr(2'd0, 1'b1, 16'h0003, 26'h0, 32'h0);
        chk("br_pos", iaddr, 32'h0000_0030);

        // Illegal jctrl acts as default (branch path)
        run_instr(2'd3, 1'b1, 16'h0001, 26'h3FF_FFFF, 32'hDEAD_BEEF);
        chk("jctrl_11", iaddr, 32'h0000_0038);

        // PC wrap
        run_instr(2'd2, 1'b0, 16'h0, 26'h0, 32'hFFFF_FFFC);
        eval();
        chk("wrap_npc", npc, 32'h0000_0000);
        run_instr(2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
        chk("wrap_pc", iaddr, 32'h0000_0000);

        // Data-memory stall
        ihit = 1'b1; instr_in = 32'h8C22_0004; eval(); adv(); clr();
        saved = iaddr;
        for (int i = 0; i < 3; i++) begin
            dmem_access = 1'b1; dhit = 1'b0; eval();
            chk("stall_pc_en", {31'd0, pc_en}, 32'd0);
            chk("stall_instr", instr_out, 32'h8C22_0004);
            chk("stall_pc", iaddr, saved);
            adv();
        end
        dmem_access = 1'b1; dhit = 1'b1; eval();
        chk("dhit_pc_en", {31'd0, pc_en}, 32'd1);
        adv(); clr(); eval();
        chk("dhit_pc", iaddr, saved + 32'd4);

        // Halt beats a simultaneous jump
        ihit = 1'b1; instr_in = 32'hFFFF_FFFF; eval(); adv(); clr();
        saved = iaddr;
        halt = 1'b1; jctrl_in = 2'd1; jaddr26 = 26'h123_4567; eval();
        chk("halt_pc_en", {31'd0, pc_en}, 32'd0);
        adv(); clr(); eval();
        chk("halt_flag", {31'd0, halted}, 32'd1);
        chk("halt_pc", iaddr, saved);
        chk("halt_iREN", {31'd0, iREN}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            ihit = 1'b1; instr_in = $urandom; eval(); adv();
        end
        clr(); eval();
        chk("halt_sticky", {31'd0, halted}, 32'd1);
        do_reset(); eval();
        chk("halt_rst_pc", iaddr, 32'h0);
        chk("halt_rst_iREN", {31'd0, iREN}, 32'd1);

        // Reset coinciding with ihit in FETCH
        run_instr(2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
        nRST = 1'b0; ihit = 1'b1; instr_in = 32'h1234_5678; eval(); adv(); clr(); eval();
        chk("rst_ihit_instr", instr_out, 32'h0);
        chk("rst_ihit_iREN", {31'd0, iREN}, 32'd1);

`ifdef FETCH_RETIRE_CNT_EN
        do_reset();
        for (int i = 0; i < 5; i++) run_instr(2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
        ihit = 1'b1; instr_in = $urandom; eval(); adv(); clr();
        halt = 1'b1; eval(); adv(); clr(); eval();
        chk("retire_six", retire_cnt, 32'd6);
        do_reset();
`endif

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            nRST         = ($urandom_range(0, 39) != 0);
            ihit         = ($urandom_range(0, 2) != 0);
            instr_in     = $urandom;
            dmem_access  = $urandom_range(0, 1) == 1;
            dhit         = ($urandom_range(0, 2) == 0);
            jctrl_in     = 2'($urandom_range(0, 3));
            branch_taken = $urandom_range(0, 1) == 1;
            imm16        = 16'($urandom);
            jaddr26      = 26'($urandom);
            jr_target    = $urandom;
            halt         = ($urandom_range(0, 23) == 0);
            eval();
            adv();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Owns the program counter and the instruction-fetch handshake for the multicycle MIPS uniprocessor.
- Sits directly upstream of the control unit. It latches the fetched word and presents it for decode. It then consumes the decoded jctrl, branch and halt results to compute and commit the next PC.
- It holds the current instruction stable until any data-memory access for that instruction completes.

Parameters:
- PC_INIT, 32'h0000_0000, PC value loaded on reset.
- WORD_W, 32, datapath/address width. Fixed at 32; other values are not supported.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- nRST  in  1  synchronous active-low reset, sampled on the rising edge of CLK.
- ihit  in  1  instruction memory has returned instr_in this cycle.
- instr_in  in  32  instruction word from memory, valid when ihit=1.
- dmem_access  in  1  current instruction performs a load or store (from the control unit).
- dhit  in  1  data memory access complete.
- jctrl_in  in  2  jctrl from cuif_types_pkg: ctrlDefault, ctrlJ or ctrlJR.
- branch_taken  in  1  conditional branch resolved taken.
- imm16  in  16  branch offset field.
- jaddr26  in  26  jump target field.
- jr_target  in  32  register value for JR.
- halt  in  1  decoded HALT.
- iREN  out  1  instruction read enable.
- iaddr  out  32  instruction address, equal to pc.
- instr_out  out  32  latched instruction, to decode.
- instr_valid  out  1  instr_out is valid (EXEC state).
- npc  out  32  pc+4, for JAL link / wctrl ctrlNPC.
- pc_en  out  1  one-cycle pulse when the PC commits.
- halted  out  1  sticky halt indicator.

Behaviour:
- States (fstate_t): FETCH, EXEC, HALTED.
- Reset: on a rising edge with nRST=0, the following load:
  - pc=PC_INIT
  - instr_out=0
  - state=FETCH
  Reset overrides every other input on the same edge, including mid-fetch and mid-EXEC.
- Output values after reset:
  - iREN=1, iaddr=PC_INIT, instr_valid=0, pc_en=0, halted=0, npc=PC_INIT+4.
- FETCH:
  - iREN=1.
  - On ihit=1: instr_out<=instr_in, go to EXEC. Fetch latency is 1 edge after ihit.
  - On ihit=0: hold.
  - dhit, halt and jctrl_in are ignored.
- EXEC:
  - iREN=0, instr_valid=1. ihit is ignored.
  - If halt=1: go to HALTED, PC not updated. Halt wins over simultaneous jump/branch/dmem.
  - Else if dmem_access=1 and dhit=0: hold, PC not updated.
  - Else: pc<=next_pc, pc_en=1 for that cycle, go to FETCH.
- next_pc priority:
  - jctrl_in=ctrlJR: jr_target.
  - jctrl_in=ctrlJ: {npc[31:28], jaddr26, 2'b00}.
  - branch_taken=1 (with ctrlDefault): npc + ({{14{imm16[15]}}, imm16, 2'b00}).
  - Otherwise: npc.
  - jctrl_in=2'b11 is illegal and is treated as ctrlDefault.
- Arithmetic: all adds are modulo 2^32, with no overflow detection. pc=32'hFFFF_FFFC gives npc=32'h0000_0000.
- Alignment: pc[1:0] is never forced. jr_target is used as given.
- HALTED:
  - halted=1, iREN=0, instr_valid=0.
  - Leaves only on reset.
- pc_en is asserted only in EXEC on the commit cycle; it is never asserted in FETCH or HALTED.

Optional Feature:
- Macro: FETCH_RETIRE_CNT_EN.
- When defined:
  - Adds output retire_cnt (32) and a counter register.
  - Reset loads 0.
  - Increments on every pc_en pulse and on the EXEC->HALTED transition.
  - Wraps modulo 2^32.
- When undefined: the port and the register are absent. All other behaviour is identical.

Decomposition:
- Add fstate_t enum {FETCH, EXEC, HALTED} to cuif_types_pkg. jctrl is reused from that package.
- Sub-module next_pc_calc: purely combinational.
  - Inputs: pc, jctrl_in, branch_taken, imm16, jaddr26, jr_target.
  - Outputs: npc, next_pc.
  - Tested standalone.

Test Plan:
- Reset then ihit=1 with instr_in=32'h2408_0005, then EXEC with all controls 0 -> instr_out=32'h2408_0005, pc_en pulse, pc=4, iREN=1.
- pc=32'h0000_0010, jctrl_in=ctrlJ, jaddr26=26'h000_0040 -> pc=32'h0000_0100. Then ctrlJR with jr_target=32'h0000_0200 -> pc=32'h0000_0200.
- pc=32'h0000_0020, branch_taken=1, imm16=16'hFFFE -> pc=32'h0000_001C. imm16=16'h0003 -> pc=32'h0000_0030.
- EXEC with dmem_access=1, dhit=0 for 3 cycles, then dhit=1 -> pc frozen and pc_en=0 for 3 cycles, single pc_en on the 4th, instr_out stable throughout.
- halt=1 with jctrl_in=ctrlJ in the same cycle -> HALTED, pc unchanged, halted=1, iREN=0. Further ihit is ignored. nRST=0 for one edge -> pc=PC_INIT, FETCH.
- nRST=0 coinciding with ihit=1 in FETCH -> instr_out=0, state FETCH. With FETCH_RETIRE_CNT_EN, 5 retired instructions plus halt -> retire_cnt=6.
